// File: rtl/uart_motor_ctrl_pkg.sv
// Shared constants for the serial motor command controller.
// Holds the packet sync byte, the parser state encoding and the led bit positions.
package motor_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CH   = 2'd1;
    localparam logic [1:0] ST_DUTY = 2'd2;
    localparam logic [1:0] ST_CHK  = 2'd3;

    localparam int LED_TIMEOUT = 7;
    localparam int LED_FERR    = 6;

    function automatic logic chk_ok(input logic [7:0] ch, input logic [7:0] duty,
                                    input logic [7:0] chk);
        return chk == (ch ^ duty);
    endfunction

endpackage

// File: rtl/uart_motor_ctrl_if.sv
// Received-byte stream from the serial receiver into the motor controller.
interface uart_motor_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input rx_data, input rx_valid);
endinterface

// File: rtl/uart_motor_ctrl_pwm_bank.sv
// Shared-counter PWM bank; new duties load only when the counter wraps so no pulse is cut short.
module pwm_bank #(
    parameter int CHANNELS = 2,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_clear_all,
    input  logic [CHANNELS-1:0][PWM_BITS-1:0]  i_shadow_duty,
    output logic [CHANNELS-1:0]                o_pwm
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PRE_W-1:0]                  r_pre;
    logic [PWM_BITS-1:0]               r_cnt;
    logic [CHANNELS-1:0][PWM_BITS-1:0] r_active;
    logic [CHANNELS-1:0]               r_pwm;
    logic                              w_tick;
    logic                              w_wrap;

    assign w_tick = (r_pre == '0);
    assign w_wrap = w_tick && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? PRE_W'(PRESCALE - 1) : r_pre - PRE_W'(1);
            if (w_tick)
                r_cnt <= w_wrap ? '0 : r_cnt + PWM_BITS'(1);
        end
    end

    // Watchdog clear overrides both the wrap load and the compare output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= '0;
            r_pwm    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_clear_all) begin
                    r_active[i] <= '0;
                    r_pwm[i]    <= 1'b0;
                end else begin
                    if (w_wrap)
                        r_active[i] <= i_shadow_duty[i];
                    r_pwm[i] <= (r_cnt < r_active[i]);
                end
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/uart_motor_ctrl.sv
// Motor command controller: parses A5/CH/DUTY/CHK packets into per-channel duty and
// direction registers, drives the PWM bank and stops all channels when commands cease.
module uart_motor_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int PWM_BITS       = 8,
    parameter int PRESCALE       = 4,
    parameter int BYTE_GAP       = 50_000,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_motor_ctrl_if.slave     rx_if,
    output logic [CHANNELS-1:0]  o_pwm_out,
    output logic [CHANNELS-1:0]  o_dir_out,
    output logic                 o_frame_err,
    output logic                 o_timeout,
    output logic [7:0]           o_led
);
    localparam int GAP_W = $clog2(BYTE_GAP + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] CH_LIMIT = 8'(CHANNELS);

    logic [1:0]                        r_rst_sync;
    logic                              w_rst_n;
    logic [1:0]                        r_state;
    logic [7:0]                        r_ch;
    logic [7:0]                        r_duty;
    logic [GAP_W-1:0]                  r_gap;
    logic [WD_W-1:0]                   r_wdog;
    logic [CHANNELS-1:0][PWM_BITS-1:0] r_shadow;
    logic [CHANNELS-1:0]               r_dir;
    logic                              r_frame_err;
    logic                              r_ferr_sticky;
    logic                              r_timeout;
    logic [5:0]                        r_led_duty;
    logic                              w_gap_exp;
    logic                              w_chk;
    logic                              w_commit;
    logic                              w_reject;
    logic                              w_expire;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rst_sync <= '0;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_gap_exp = (r_state != ST_IDLE) && !rx_if.rx_valid
                       && (r_gap == GAP_W'(BYTE_GAP - 1));
    assign w_chk     = rx_if.rx_valid && (r_state == ST_CHK);
    assign w_commit  = w_chk && chk_ok(r_ch, r_duty, rx_if.rx_data)
                       && ({1'b0, r_ch[6:0]} < CH_LIMIT);
    assign w_reject  = w_chk && !w_commit;
    assign w_expire  = !w_commit && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_duty  <= '0;
        end else if (w_gap_exp) begin
            r_state <= ST_IDLE;
        end else if (rx_if.rx_valid) begin
            case (r_state)
                ST_IDLE: if (rx_if.rx_data == SYNC_BYTE) r_state <= ST_CH;
                ST_CH: begin
                    r_ch    <= rx_if.rx_data;
                    r_state <= ST_DUTY;
                end
                ST_DUTY: begin
                    r_duty  <= rx_if.rx_data;
                    r_state <= ST_CHK;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_gap <= '0;
        else if ((r_state == ST_IDLE) || rx_if.rx_valid || w_gap_exp)
            r_gap <= '0;
        else
            r_gap <= r_gap + GAP_W'(1);
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shadow      <= '0;
            r_dir         <= '0;
            r_led_duty    <= '0;
            r_frame_err   <= 1'b0;
            r_ferr_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_expire)
                    r_shadow[i] <= '0;
                else if (w_commit && (r_ch[6:0] == 7'(i))) begin
                    r_shadow[i] <= r_duty[7 -: PWM_BITS];
                    r_dir[i]    <= r_ch[7];
                end
            end
            if (w_commit)
                r_led_duty <= r_duty[5:0];
            r_frame_err <= w_reject || w_gap_exp;
            if (w_reject || w_gap_exp)
                r_ferr_sticky <= 1'b1;
        end
    end

    // Counter saturates at the limit so expiry fires once per silence.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (w_commit) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_wdog != WD_W'(TIMEOUT_CYCLES))
                r_wdog <= r_wdog + WD_W'(1);
            if (w_expire)
                r_timeout <= 1'b1;
        end
    end

    pwm_bank #(
        .CHANNELS (CHANNELS),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm_bank (
        .i_clk         (i_clk),
        .i_rst_n       (w_rst_n),
        .i_clear_all   (w_expire),
        .i_shadow_duty (r_shadow),
        .o_pwm         (o_pwm_out)
    );

    always_comb begin
        o_led              = {2'b00, r_led_duty};
        o_led[LED_TIMEOUT] = r_timeout;
        o_led[LED_FERR]    = r_ferr_sticky;
    end

    assign o_dir_out   = r_dir;
    assign o_frame_err = r_frame_err;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_motor_ctrl.sv
// Randomised packet stimulus against a packet-level model of the motor controller.
module tb_uart_motor_ctrl;
    localparam int CH     = 2;
    localparam int PRE    = 4;
    localparam int GAP    = 500;
    localparam int PERIOD = 255 * PRE;
    localparam int WD_B   = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_motor_ctrl_if rx_if ();

    logic [CH-1:0] a_pwm, a_dir, b_pwm, b_dir;
    logic          a_ferr, a_tmo, b_ferr, b_tmo;
    logic [7:0]    a_led, b_led;

    uart_motor_ctrl #(.CHANNELS(CH), .PWM_BITS(8), .PRESCALE(PRE), .BYTE_GAP(GAP),
                      .TIMEOUT_CYCLES(1_000_000)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .rx_if(rx_if), .o_pwm_out(a_pwm), .o_dir_out(a_dir),
        .o_frame_err(a_ferr), .o_timeout(a_tmo), .o_led(a_led));

    uart_motor_ctrl #(.CHANNELS(CH), .PWM_BITS(8), .PRESCALE(1), .BYTE_GAP(GAP),
                      .TIMEOUT_CYCLES(WD_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .rx_if(rx_if), .o_pwm_out(b_pwm), .o_dir_out(b_dir),
        .o_frame_err(b_ferr), .o_timeout(b_tmo), .o_led(b_led));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-level model of dut_a
    int         m_duty [CH];
    bit         m_dir  [CH];
    logic [5:0] m_led;
    bit         m_sticky;
    int         m_err_cnt = 0;
    logic [7:0] pkt_q[$];
    int         err_seen = 0;

    always @(negedge clk) if (a_ferr === 1'b1) err_seen++;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_dir[i]  = 1'b0;
        end
        m_led    = '0;
        m_sticky = 1'b0;
        pkt_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] c, d, k;
        if (pkt_q.size() == 0 && b != 8'hA5) return;
        pkt_q.push_back(b);
        if (pkt_q.size() == 4) begin
            c = pkt_q[1];
            d = pkt_q[2];
            k = pkt_q[3];
            if (k == (c ^ d) && int'(c[6:0]) < CH) begin
                m_duty[int'(c[6:0])] = int'(d);
                m_dir[int'(c[6:0])]  = c[7];
                m_led = d[5:0];
            end else begin
                m_err_cnt++;
                m_sticky = 1'b1;
            end
            pkt_q.delete();
        end
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                            input bit gaps);
        logic [7:0] bytes [4];
        bytes = '{8'hA5, c, d, k};
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 30)) @(negedge clk);
            send(bytes[i]);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < CH; i++)
            check_eq($sformatf("%s dir%0d", tag, i), a_dir[i], m_dir[i]);
        check_eq({tag, " led_duty"}, a_led[5:0], m_led);
        check_eq({tag, " led_ferr"}, a_led[6], m_sticky);
        #1;
        check_eq({tag, " ferr_count"}, err_seen, m_err_cnt);
    endtask

    task automatic measure(input string tag);
        int hi [CH];
        for (int i = 0; i < CH; i++) hi[i] = 0;
        repeat (PERIOD + 10) @(negedge clk);
        repeat (PERIOD) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) if (a_pwm[i]) hi[i]++;
        end
        for (int i = 0; i < CH; i++)
            check_eq($sformatf("%s pwm_hi%0d", tag, i), hi[i], m_duty[i] * PRE);
    endtask

    initial begin
        int lat, first_t, hi_b, hi_after;
        logic [7:0] c, d, k;
        rx_if.rx_data  = '0;
        rx_if.rx_valid = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_eq("rst pwm", a_pwm, 0);
        check_eq("rst dir", a_dir, 0);
        check_eq("rst ferr", a_ferr, 0);
        check_eq("rst timeout", a_tmo, 0);
        check_eq("rst led", a_led, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_pkt(8'h01, 8'h80, 8'h81, 0);
        check_state("t1");
        measure("t1");

        send_pkt(8'h80, 8'hFF, 8'h7F, 0);
        check_eq("t2 dir0", a_dir[0], 1'b1);
        check_state("t2");
        measure("t2");
        send_pkt(8'h00, 8'h00, 8'h00, 0);
        check_state("t2b");
        measure("t2b");

        send_pkt(8'h00, 8'h40, 8'h41, 0);
        check_eq("bad_chk ferr", a_ferr, 1'b1);
        check_state("bad_chk");
        send_pkt(8'h05, 8'h40, 8'h45, 0);
        check_state("bad_idx");
        measure("bad");

        // Inter-byte gap abort
        send(8'hA5);
        send(8'h00);
        lat = -1;
        for (int i = 1; i <= GAP + 20; i++) begin
            @(negedge clk);
            if (a_ferr) begin
                lat = i;
                break;
            end
        end
        check_eq("gap latency", lat, GAP);
        pkt_q.delete();
        m_err_cnt++;
        m_sticky = 1'b1;
        check_state("gap");
        send_pkt(8'h81, 8'h33, 8'hB2, 0);
        check_state("after_gap");

        // Randomised rounds
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                case ($urandom_range(0, 3))
                    0: begin
                        c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, CH - 1))};
                        d = 8'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                        k = c ^ d;
                    end
                    1: begin
                        c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, CH - 1))};
                        d = 8'($urandom_range(0, 255));
                        k = (c ^ d) ^ 8'(1 << $urandom_range(0, 7));
                    end
                    2: begin
                        c = {1'($urandom_range(0, 1)), 7'($urandom_range(CH, 127))};
                        d = 8'($urandom_range(0, 255));
                        k = c ^ d;
                    end
                    default: begin
                        repeat ($urandom_range(1, 3)) begin
                            d = 8'($urandom_range(0, 255));
                            send((d == 8'hA5) ? 8'h5A : d);
                        end
                        c = {1'($urandom_range(0, 1)), 7'($urandom_range(0, CH - 1))};
                        d = 8'($urandom_range(0, 255));
                        k = c ^ d;
                    end
                endcase
                send_pkt(c, d, k, 1);
                check_state($sformatf("rnd%0d", r));
            end
            measure($sformatf("rnd%0d", r));
        end

        // Watchdog on dut_b (TIMEOUT 1000, PRESCALE 1)
        send_pkt(8'h00, 8'h80, 8'h80, 0);
        check_eq("wd cleared", b_tmo, 1'b0);
        check_eq("wd led7 clr", b_led[7], 1'b0);
        first_t  = -1;
        hi_b     = 0;
        hi_after = 0;
        for (int i = 1; i <= WD_B + 300; i++) begin
            @(negedge clk);
            if (i >= 300 && i < 555 && b_pwm[0]) hi_b++;
            if (i > first_t && first_t > 0 && b_pwm != 0) hi_after++;
            if (b_tmo && first_t < 0) begin
                first_t = i;
                check_eq("wd pwm at stop", b_pwm, 0);
                check_eq("wd led7", b_led[7], 1'b1);
            end
        end
        check_eq("wd pwm before", hi_b, 128);
        check_eq("wd expiry cycle", first_t, WD_B);
        check_eq("wd pwm after", hi_after, 0);
        send_pkt(8'h01, 8'h20, 8'h21, 0);
        check_eq("wd recommit", b_tmo, 1'b0);
        check_eq("wd recommit led7", b_led[7], 1'b0);
        check_state("wd_a");

        // Asynchronous reset mid-packet
        send(8'hA5);
        send(8'h80);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst a_pwm", a_pwm, 0);
        check_eq("arst a_dir", a_dir, 0);
        check_eq("arst a_led", a_led, 0);
        check_eq("arst b_pwm", b_pwm, 0);
        check_eq("arst b_dir", b_dir, 0);
        check_eq("arst b_led", b_led, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_pkt(8'h81, 8'hC0, 8'h41, 0);
        check_state("post_rst");
        measure("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_motor_ctrl.md
# uart_motor_ctrl

Parametrised motor command controller that sits between the byte-level serial receiver and the motor driver pins. It parses checksummed command packets from the received byte stream and holds a duty and direction register per channel. It drives CHANNELS glitch-free PWM outputs from those registers. A watchdog forces every channel to zero duty when valid commands stop arriving.

## Interface
- CHANNELS, 2: number of PWM/direction channel pairs (1..16)
- PWM_BITS, 8: PWM resolution (1..8); duty = upper PWM_BITS bits of the DUTY byte
- PRESCALE, 4: clk cycles per PWM counter tick (≥1)
- BYTE_GAP, 50_000: max clk cycles between bytes of one packet
- TIMEOUT_CYCLES, 25_000_000: clk cycles without a valid commit before watchdog stop
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  single-cycle strobe per received byte
- pwm_out  out  CHANNELS  PWM per channel, registered
- dir_out  out  CHANNELS  direction per channel, registered
- frame_err  out  1  one-cycle pulse on a rejected packet
- timeout  out  1  high while the watchdog stop is active
- led  out  8  status: [7]=timeout, [6]=sticky frame error, [5:0]=low 6 bits of last committed duty byte

## Operation
- Packet is 4 bytes: SYNC=0xA5, CH, DUTY, CHK. CH[7] is dir and CH[6:0] is the channel index. CHK must equal CH^DUTY.
- Parser FSM: IDLE -> (byte==0xA5) S_CH -> S_DUTY -> S_CHK -> IDLE.
  - In IDLE, bytes other than 0xA5 are discarded silently.
  - In S_CH, S_DUTY and S_CHK, every byte is taken as data, including 0xA5. There is no mid-packet resync.
- On the CHK byte:
  - If the checksum matches and index < CHANNELS: commit. shadow_duty[idx] ← DUTY[7:8-PWM_BITS], dir[idx] ← CH[7], watchdog cleared, timeout cleared, led[5:0] ← DUTY[5:0].
  - Otherwise: frame_err pulse and led[6] set. led[6] clears only on reset.
- Inter-byte gap: in any non-IDLE state, BYTE_GAP cycles without rx_valid returns the FSM to IDLE and pulses frame_err.
- PWM: one shared counter advances once per PRESCALE-cycle tick and runs 0..2^PWM_BITS-2, wrapping to 0. Period = (2^PWM_BITS-1)·PRESCALE cycles.
  - pwm_out[i] = (cnt < active_duty[i]). Duty 0 gives constant low; duty all-ones gives constant high.
  - active_duty[i] ← shadow_duty[i] only on the tick where cnt wraps to 0. No truncated or extended pulses.
- dir_out updates immediately on commit, with no period alignment.
- Watchdog: counts every cycle while no commit occurs. On reaching TIMEOUT_CYCLES:
  - All shadow and active duties are cleared to 0 immediately, without waiting for a period boundary.
  - timeout ← 1 and the counter saturates.
  - dir is unchanged.
- Simultaneous commit and watchdog expiry in the same cycle: the commit wins and the watchdog restarts.

## Timing
- Reset state (rst_n low, asynchronous): pwm_out=0, dir_out=0, frame_err=0, timeout=0, led=0, FSM=IDLE, all counters and duties 0.
- rx_valid with CHK in cycle N: shadow_duty, dir_out, led and the watchdog clear are visible after the clk edge ending N. frame_err is high during cycle N+1 only.
- New duty appears on pwm_out one cycle after the first counter wrap following the commit. Worst-case latency is one PWM period + 2 cycles.
- Back-to-back rx_valid on consecutive cycles must be accepted. No byte is ever dropped.
- Reset asserted mid-packet or mid-period: everything returns to the reset state immediately.
- Reset release is synchronised internally with a 2-flop deassertion synchroniser.

## Structure
- Package motor_ctrl_pkg holds:
  - SYNC_BYTE constant (8'hA5)
  - parser state encoding (IDLE, S_CH, S_DUTY, S_CHK)
  - led bit-index constants
- Sub-module pwm_bank(CHANNELS, PWM_BITS, PRESCALE):
  - owns the prescaler, the shared counter, the active_duty registers and the wrap-aligned load
  - has a synchronous clear_all input for the watchdog
- Top module holds the parser FSM, gap counter, shadow/dir registers, watchdog and led.

## Test plan
- Defaults, send A5 01 80 81 → after the next wrap, pwm_out[1] is high for 128 of 255 ticks (512 of 1020 cycles). dir_out[1]=0 right after the CHK byte.
- Send A5 80 FF 7F → dir_out[0]=1 one cycle after CHK. After the wrap, pwm_out[0] is constant high. A following A5 00 00 00 gives constant low from the next wrap.
- Bad checksum A5 00 40 41 → frame_err pulses exactly once and led[6]=1. Duties are unchanged.
- Channel index out of range: A5 05 40 45 with CHANNELS=2 → frame_err pulse and no register change.
- Gap: send A5 00, then idle BYTE_GAP cycles → frame_err pulse and FSM in IDLE. A following full packet is accepted.
- Watchdog: TIMEOUT_CYCLES=1000, commit duty 0x80, then idle 1000 cycles → pwm_out=0 immediately and timeout=led[7]=1. The next valid commit clears timeout. Assert rst_n low mid-packet → all outputs 0 asynchronously.
